// File: rtl/imem_program_loader.sv
// imem_program_loader
//
// Fills instruction memory from a framed byte stream and gates the CPU.
// Frame: LEN_HI, LEN_LO (word count N, big-endian), 4N payload bytes
// (each word MSB first), then one checksum byte (XOR of all payload bytes).
// The CPU is released only after a frame is fully written and its checksum
// matches.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   start        one-cycle pulse, begins a load from IDLE, DONE or ERROR
//   in_valid     source presents a byte on in_data
//   in_data      stream byte
//   in_ready     loader accepts in_data this cycle (decoded from state)
//   mem_we       instruction memory byte write enable (registered)
//   mem_addr     instruction memory byte address (registered)
//   mem_wd       instruction memory write byte (registered)
//   cpu_run      high = CPU may execute
//   busy         a frame is in progress
//   done         last frame loaded and verified
//   error        last frame rejected
//   words_loaded complete 32-bit words written in the current/last frame
module imem_program_loader #(
    parameter int unsigned MEM_BYTES = 64,
    parameter logic [31:0] BASE_ADDR = 32'd0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [7:0]  mem_wd,
    output logic        cpu_run,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [15:0] words_loaded
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_PAYLOAD,
        S_CHECK,
        S_DONE,
        S_ERROR
    } state_t;

    localparam logic [17:0] MEM_LIMIT = 18'(MEM_BYTES);

    state_t      state_reg, state_next;
    logic [15:0] len_reg;
    logic [16:0] byte_idx_reg;
    logic [15:0] words_reg;
    logic [7:0]  chk_reg;
    logic        mem_we_reg;
    logic [31:0] mem_addr_reg;
    logic [7:0]  mem_wd_reg;

    logic        xfer;
    logic [15:0] len_full;
    logic [17:0] len_full_x4;
    logic [17:0] payload_bytes;
    logic        last_byte;
    logic        enter_len_hi;

    assign xfer = in_valid & in_ready;

    // Length as it will be once LEN_LO is latched; the oversize test must
    // look at the incoming low byte in the same cycle it is accepted.
    assign len_full      = {len_reg[15:8], in_data};
    assign len_full_x4   = {len_full, 2'b00};
    assign payload_bytes = {len_reg, 2'b00};
    assign last_byte     = (({1'b0, byte_idx_reg}) + 18'd1) == payload_bytes;

    assign enter_len_hi  = (state_next == S_LEN_HI) && (state_reg != S_LEN_HI);

    always_comb begin
        state_next = state_reg;
        in_ready   = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        error      = 1'b0;
        cpu_run    = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (start) state_next = S_LEN_HI;
            end
            S_LEN_HI: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (in_valid) state_next = S_LEN_LO;
            end
            S_LEN_LO: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (in_valid) begin
                    if (len_full_x4 > MEM_LIMIT) begin
                        state_next = S_ERROR;
                    end else if (len_full == 16'd0) begin
                        state_next = S_CHECK;
                    end else begin
                        state_next = S_PAYLOAD;
                    end
                end
            end
            S_PAYLOAD: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (in_valid && last_byte) state_next = S_CHECK;
            end
            S_CHECK: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (in_valid) begin
                    if (in_data == chk_reg) begin
                        state_next = S_DONE;
                    end else begin
                        state_next = S_ERROR;
                    end
                end
            end
            S_DONE: begin
                done    = 1'b1;
                cpu_run = 1'b1;
                if (start) state_next = S_LEN_HI;
            end
            S_ERROR: begin
                error = 1'b1;
                if (start) state_next = S_LEN_HI;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= S_IDLE;
            len_reg      <= 16'd0;
            byte_idx_reg <= 17'd0;
            words_reg    <= 16'd0;
            chk_reg      <= 8'd0;
            mem_we_reg   <= 1'b0;
            mem_addr_reg <= 32'd0;
            mem_wd_reg   <= 8'd0;
        end else begin
            state_reg  <= state_next;
            mem_we_reg <= 1'b0;

            if (enter_len_hi) begin
                len_reg      <= 16'd0;
                byte_idx_reg <= 17'd0;
                words_reg    <= 16'd0;
                chk_reg      <= 8'd0;
            end

            if (xfer && state_reg == S_LEN_HI) len_reg[15:8] <= in_data;
            if (xfer && state_reg == S_LEN_LO) len_reg[7:0]  <= in_data;

            if (xfer && state_reg == S_PAYLOAD) begin
                chk_reg      <= chk_reg ^ in_data;
                byte_idx_reg <= byte_idx_reg + 17'd1;
                if (byte_idx_reg[1:0] == 2'd3) words_reg <= words_reg + 16'd1;
                // Address uses the index of this byte, before the increment.
                mem_we_reg   <= 1'b1;
                mem_addr_reg <= BASE_ADDR + {15'd0, byte_idx_reg};
                mem_wd_reg   <= in_data;
            end
        end
    end

    assign mem_we       = mem_we_reg;
    assign mem_addr     = mem_addr_reg;
    assign mem_wd       = mem_wd_reg;
    assign words_loaded = words_reg;

endmodule

// File: tb/tb_imem_program_loader.sv
module tb_imem_program_loader;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [7:0]  mem_wd;
    logic        cpu_run;
    logic        busy;
    logic        done;
    logic        error;
    logic [15:0] words_loaded;

    int pass_cnt = 0;
    int total_cnt = 0;

    logic [7:0]  frm[$];
    logic [31:0] wr_a[$];
    logic [7:0]  wr_d[$];

    imem_program_loader #(
        .MEM_BYTES(64),
        .BASE_ADDR(32'd0)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wd      (mem_wd),
        .cpu_run     (cpu_run),
        .busy        (busy),
        .done        (done),
        .error       (error),
        .words_loaded(words_loaded)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Write-port monitor: each pulse is one cycle wide, so one sample per
    // falling edge records each write exactly once.
    always @(negedge clk) begin
        if (mem_we) begin
            wr_a.push_back(mem_addr);
            wr_d.push_back(mem_wd);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        if (obs === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_data  = 8'($urandom);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_busy", {31'd0, busy}, 32'd1);
        check("start_cpu_run", {31'd0, cpu_run}, 32'd0);
        check("start_done_err", {30'd0, done, error}, 32'd0);
    endtask

    // Present one byte, wait (bounded) for acceptance, then look at the
    // write port one cycle later when the byte is payload.
    task automatic send_byte(input logic [7:0] b, input bit is_payload, input int exp_addr);
        int guard;
        guard = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) check("ready_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (is_payload) begin
            check("wr_we_latency", {31'd0, mem_we}, 32'd1);
            check("wr_addr_now", mem_addr, 32'(exp_addr));
            check("wr_data_now", {24'd0, mem_wd}, {24'd0, b});
        end
    endtask

    task automatic run_frame(input int gap, input int exp_words, input bit exp_ok);
        bit pl;
        wr_a.delete();
        wr_d.delete();
        for (int i = 0; i < frm.size(); i++) begin
            pl = (i >= 2) && (i < frm.size() - 1);
            if (i > 0) idle(gap);
            send_byte(frm[i], pl, i - 2);
        end
        check("wr_count", 32'(wr_a.size()), 32'(exp_words * 4));
        for (int i = 0; i < wr_a.size() && i < exp_words * 4; i++) begin
            check("wr_addr_seq", wr_a[i], 32'(i));
            check("wr_data_seq", {24'd0, wr_d[i]}, {24'd0, frm[i + 2]});
        end
        check("frame_words", {16'd0, words_loaded}, 32'(exp_words));
        check("frame_done", {31'd0, done}, {31'd0, exp_ok});
        check("frame_cpu_run", {31'd0, cpu_run}, {31'd0, exp_ok});
        check("frame_error", {31'd0, error}, {31'd0, !exp_ok});
        check("frame_busy", {31'd0, busy}, 32'd0);
        $display("frame len=%0d gap=%0d writes=%0d done=%0b error=%0b",
                 exp_words, gap, wr_a.size(), done, error);
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'd0;

        // Reset state
        #7;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_outs", {27'd0, cpu_run, done, error, in_ready, mem_we}, 32'd0);
        check("rst_words", {16'd0, words_loaded}, 32'd0);
        check("rst_addr", mem_addr, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        $display("reset released");

        // Single word, checksum 20^01^FF^FD = 23
        pulse_start();
        frm = '{8'h00, 8'h01, 8'h20, 8'h01, 8'hFF, 8'hFD, 8'h23};
        run_frame(0, 1, 1'b1);

        // Bad checksum: writes still happen, then ERROR
        pulse_start();
        frm = '{8'h00, 8'h01, 8'h20, 8'h01, 8'hFF, 8'hFD, 8'h24};
        run_frame(0, 1, 1'b0);

        // Oversize: N=17 -> 68 bytes > 64
        pulse_start();
        wr_a.delete();
        wr_d.delete();
        send_byte(8'h00, 1'b0, 0);
        send_byte(8'h11, 1'b0, 0);
        check("ovr_error", {31'd0, error}, 32'd1);
        check("ovr_busy", {31'd0, busy}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = 8'(8'hA0 + i);
            check("ovr_ready", {31'd0, in_ready}, 32'd0);
        end
        @(negedge clk);
        in_valid = 1'b0;
        check("ovr_no_writes", 32'(wr_a.size()), 32'd0);
        $display("oversize error=%0b writes=%0d", error, wr_a.size());

        // Backpressure: two words with two idle cycles between bytes
        pulse_start();
        frm = '{8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44,
                8'h55, 8'h66, 8'h77, 8'h88, 8'h88};
        run_frame(2, 2, 1'b1);

        // Zero length, good and bad checksum
        pulse_start();
        frm = '{8'h00, 8'h00, 8'h00};
        run_frame(0, 0, 1'b1);
        pulse_start();
        frm = '{8'h00, 8'h00, 8'h01};
        run_frame(1, 0, 1'b0);

        // Reset in the middle of a payload
        pulse_start();
        send_byte(8'h00, 1'b0, 0);
        send_byte(8'h01, 1'b0, 0);
        send_byte(8'hAA, 1'b1, 0);
        send_byte(8'hBB, 1'b1, 1);
        send_byte(8'hCC, 1'b1, 2);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_we", {31'd0, mem_we}, 32'd0);
        check("mid_rst_addr", mem_addr, 32'd0);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_ready", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        $display("mid-load reset applied");
        pulse_start();
        frm = '{8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h08};
        run_frame(0, 1, 1'b1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
